traffic_gen_param: RTL
======================

// Module: traffic_gen_param
// PURPOSE
// Parametrised per-node traffic generator for the ROWS x COLUMNS mesh, driving a router LOCAL_PORT.
// Injects multi-flit packets (HEAD/BODY/TAIL, or SINGLE when PKT_LEN=1) at an LFSR-controlled rate.
// Selectable destination patterns; obeys the router on/off flow control; stops after a packet budget.
// Replaces the fixed single-flit generator in mesh benches and synthetic-load runs.
// PARAMETERS
// ROWS      4       mesh rows; the X address ranges over 0..ROWS-1
// COLUMNS   4       mesh columns; the Y address ranges over 0..COLUMNS-1
// SRC_X     0       this node's X address
// SRC_Y     0       this node's Y address
// FLIT_W    32      flit width, >= 2+2*AW+16 (AW = clog2(max(ROWS,COLUMNS)))
// PKT_LEN   4       flits per packet, >= 1
// INJ_RATE  64      injection threshold, 0..256: new packet when lfsr[7:0] < INJ_RATE
// MAX_PKTS  16      packets to send before DONE; 0 = unlimited
// HOT_X     0       hotspot X address (mode 2)
// HOT_Y     0       hotspot Y address (mode 2)
// SEED      16'hACE1  LFSR seed, nonzero
// PORTS
// clk           in   1       clock, rising edge
// reset_n       in   1       synchronous reset, ACTIVE-HIGH: reset_n=1 at a rising edge resets the block
// i_start       in   1       level enable; 0 = no new packets start (a packet in flight completes)
// i_mode        in   2       0 uniform random, 1 transpose, 2 hotspot, 3 east neighbour; sampled at HEAD build
// i_send        in   1       router on/off: 1 = the downstream can accept a flit this cycle
// o_flit        out  FLIT_W  flit: [W-1:W-2] type, dest X, dest Y, then payload {seq[7:0], idx[7:0]} in the LSBs
// o_transmit    out  1       flit valid (request)
// o_pkt_count   out  16      count of fully sent packets (TAIL/SINGLE accepted); saturates at 16'hFFFF
// o_busy        out  1       1 while a packet is in flight
// o_done        out  1       1 once MAX_PKTS packets are sent; sticky until reset
// BEHAVIOUR
// - Flit types: 01 HEAD, 00 BODY, 10 TAIL, 11 SINGLE.
// - Reset: all outputs 0. LFSR=SEED, seq=0, state IDLE.
// - LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle that is not reset.
// - Transfer: a flit moves on a cycle with o_transmit=1 && i_send=1.
//   While o_transmit=1 && i_send=0, o_flit and o_transmit hold stable (no drop, no change).
// - FSM states: IDLE, INJ, SEND, DONE.
//   IDLE: if o_done condition is met -> DONE.
//         else if i_start && lfsr[7:0] < INJ_RATE -> build HEAD/SINGLE -> SEND, with o_transmit=1 on the next cycle.
//         Therefore INJ_RATE=256 gives a HEAD one cycle after i_start rises, and INJ_RATE=0 never injects.
//   SEND: on each accepted flit, idx++. If the accepted flit was TAIL/SINGLE: o_pkt_count++, seq++.
//         Then -> IDLE, with o_transmit=0 for at least one cycle between packets.
//         Otherwise present the next flit the following cycle: BODY for idx<PKT_LEN-1, TAIL for idx=PKT_LEN-1.
//   DONE: o_transmit=0 and o_done=1 permanently. MAX_PKTS=0 never enters DONE.
// - The destination is latched at HEAD build and is identical in every flit of the packet. Per mode:
//   0: X = lfsr[15:8] mod ROWS, Y = lfsr[7:0] mod COLUMNS. If this equals (SRC_X,SRC_Y), Y = (Y+1) mod COLUMNS.
//   1: (X,Y) = (SRC_Y mod ROWS, SRC_X mod COLUMNS).
//   2: (X,Y) = (HOT_X, HOT_Y).
//   3: X = SRC_X, Y = (SRC_Y+1) mod COLUMNS (wraps).
// - Payload: seq = packet number mod 256 (wraps 255->0); idx = 0 for HEAD, incrementing per flit.
// - i_start falling mid-packet: the packet completes. i_send low indefinitely: stall with no timeout.
// - Reset mid-packet: the packet is abandoned, o_transmit=0 the next cycle, and counters clear.
// - o_busy = (state==SEND).
// TESTING
// T1 PKT_LEN=4, INJ_RATE=256, mode 3, SRC=(1,3), i_send=1:
//    types 01,00,00,10; dest (1,0); idx 0..3; o_pkt_count=1 after the TAIL.
// T2 PKT_LEN=1, MAX_PKTS=3, INJ_RATE=256: 3 SINGLE flits with seq 0,1,2.
//    o_done=1 and o_transmit stuck at 0; o_pkt_count=3.
// T3 T1 config, i_send=0 for 5 cycles during BODY idx=1:
//    o_flit is unchanged for all 5 cycles, and the packet ends with exactly 4 transfers.
// T4 Mode 0, 4x4 mesh, SRC=(2,2), 1000 packets:
//    every dest is in range and never (2,2); every flit in a packet carries the same dest.
// T5 Mode 1, SRC=(1,3): dest=(3,1). Mode 2, HOT=(0,0): dest=(0,0).
//    Reset (reset_n=1) during BODY: o_transmit=0 the next cycle, o_pkt_count=0.
// T6 INJ_RATE=0 with i_start=1 for 200 cycles: o_transmit never asserts.
//    Then 256 packets sent: seq wraps to 0 on the 257th packet.

Source files
------------

// File: rtl/traffic_gen_param.sv
// Synthetic-load traffic generator for one mesh node: LFSR-paced multi-flit packets
// into a router local port, with on/off flow control and an optional packet budget.
module traffic_gen_param #(
    parameter int          ROWS     = 4,
    parameter int          COLUMNS  = 4,
    parameter int          SRC_X    = 0,
    parameter int          SRC_Y    = 0,
    parameter int          FLIT_W   = 32,
    parameter int          PKT_LEN  = 4,
    parameter int          INJ_RATE = 64,
    parameter int          MAX_PKTS = 16,
    parameter int          HOT_X    = 0,
    parameter int          HOT_Y    = 0,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic [1:0]        i_mode,
    input  logic              i_send,
    output logic [FLIT_W-1:0] o_flit,
    output logic              o_transmit,
    output logic [15:0]       o_pkt_count,
    output logic              o_busy,
    output logic              o_done
);
    localparam int MAXD = (ROWS > COLUMNS) ? ROWS : COLUMNS;
    localparam int AW   = (MAXD > 1) ? $clog2(MAXD) : 1;

    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    // HEAD build is folded into the IDLE exit so INJ_RATE=256 injects one cycle after start;
    // INJ is kept in the encoding but never entered.
    typedef enum logic [1:0] {IDLE, INJ, SEND, DONE} state_t;

    typedef struct packed {
        logic [1:0]    typ;
        logic [AW-1:0] dx;
        logic [AW-1:0] dy;
    } hdr_t;

    state_t      state_q, state_d;
    hdr_t        hdr_q, hdr_d;
    logic [7:0]  seq_q, seq_d;
    logic [15:0] idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic        xmit_q, xmit_d;
    logic [15:0] lfsr_q;

    logic [AW-1:0] dst_x, dst_y;
    int            rx, ry;
    logic          inject, budget_hit, accept;

    always_comb begin
        rx = int'(lfsr_q[15:8]) % ROWS;
        ry = int'(lfsr_q[7:0]) % COLUMNS;
        if (rx == SRC_X && ry == SRC_Y) ry = (ry + 1) % COLUMNS;
        dst_x = AW'(SRC_X);
        dst_y = AW'((SRC_Y + 1) % COLUMNS);
        case (i_mode)
            2'd0: begin dst_x = AW'(rx);              dst_y = AW'(ry);                 end
            2'd1: begin dst_x = AW'(SRC_Y % ROWS);    dst_y = AW'(SRC_X % COLUMNS);    end
            2'd2: begin dst_x = AW'(HOT_X);           dst_y = AW'(HOT_Y);              end
            default: ;
        endcase
    end

    assign inject     = i_start && (int'(lfsr_q[7:0]) < INJ_RATE);
    assign budget_hit = (MAX_PKTS != 0) && (int'(cnt_q) >= MAX_PKTS);
    assign accept     = xmit_q && i_send;

    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        seq_d   = seq_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        xmit_d  = xmit_q;
        case (state_q)
            IDLE: begin
                xmit_d = 1'b0;
                if (budget_hit) begin
                    state_d = DONE;
                end else if (inject) begin
                    state_d   = SEND;
                    xmit_d    = 1'b1;
                    idx_d     = '0;
                    hdr_d.typ = (PKT_LEN == 1) ? T_SINGLE : T_HEAD;
                    hdr_d.dx  = dst_x;
                    hdr_d.dy  = dst_y;
                end
            end
            SEND: begin
                // flit fields only move on acceptance, so a stalled flit holds
                if (accept) begin
                    idx_d = idx_q + 16'd1;
                    if (hdr_q.typ == T_TAIL || hdr_q.typ == T_SINGLE) begin
                        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                        seq_d   = seq_q + 8'd1;
                        xmit_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        hdr_d.typ = (int'(idx_d) < PKT_LEN - 1) ? T_BODY : T_TAIL;
                    end
                end
            end
            DONE:    xmit_d = 1'b0;
            default: begin
                state_d = IDLE;
                xmit_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q <= IDLE;
            hdr_q   <= '0;
            seq_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            xmit_q  <= 1'b0;
            lfsr_q  <= SEED;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            seq_q   <= seq_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            xmit_q  <= xmit_d;
            lfsr_q  <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    always_comb begin
        o_flit                     = '0;
        o_flit[FLIT_W-1 -: 2]      = hdr_q.typ;
        o_flit[FLIT_W-3 -: AW]     = hdr_q.dx;
        o_flit[FLIT_W-3-AW -: AW]  = hdr_q.dy;
        o_flit[15:0]               = {seq_q, idx_q[7:0]};
    end

    assign o_transmit  = xmit_q;
    assign o_pkt_count = cnt_q;
    assign o_busy      = (state_q == SEND);
    assign o_done      = (state_q == DONE);

endmodule
